csi_pkt_sequencer: RTL and testbench
====================================

Name: csi_pkt_sequencer

Overview:
- Packet-control stage between pix2byte and the csi_tx packetizer.
- Turns the frame/line boundary pulses and the byte stream from pix2byte into short/long packet requests (sp_en, lp_en, dt, wc) for csi_tx.
- Aligns the byte data, and the returned d_hs_rdy, to a fixed pipeline delay.
- Tracks frame/line state and flags sequencing and byte-count errors for debug.

Parameters:
- H_PIXELS, 256, active pixels per line.
- BPP, 10, bits per pixel; WC = H_PIXELS*BPP/8 (320 at defaults); H_PIXELS*BPP must be divisible by 8.
- DATA_DLY, 3, byte_data/byte_en delay in cycles, range 1..8.
- FRAME_NUM_MAX, 16'd65535, frame-number wrap point (used only with CSI_FRAME_NUM_EN).

Ports:
- hf_clk90  in  1  clock.
- reset_n_byte  in  1  asynchronous, active-low reset.
- fv_start_i  in  1  frame-start pulse.
- fv_end_i  in  1  frame-end pulse.
- lv_start_i  in  1  line-start pulse.
- lv_end_i  in  1  line-end pulse.
- byte_en_i  in  1  byte valid.
- byte_data_i  in  8  byte payload.
- d_hs_rdy_i  in  1  HS-ready from csi_tx.
- sp_en_o  out  1  short-packet request.
- lp_en_o  out  1  long-packet request.
- dt_o  out  6  data type.
- wc_o  out  16  word count / short-packet data field.
- byte_en_o  out  1  delayed byte valid.
- byte_data_o  out  8  delayed byte payload.
- txfr_en_o  out  1  d_hs_rdy_i delayed 1 cycle (to pix2byte).
- frame_active_o  out  1  high between FS and FE.
- seq_err_o  out  1  sticky boundary-sequence error.
- wc_err_o  out  1  sticky byte-count mismatch.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Event priority when pulses coincide: fv_start > fv_end > lv_start (one packet request per cycle).
  - Exception: lv_end together with fv_end. The line check is performed first in that cycle; FE is still emitted.
- sp_en_o and lp_en_o are single-cycle pulses, registered 1 cycle after the causing input pulse.
- dt_o/wc_o update in the same cycle as the pulse and hold until the next event.
  - FS: dt 6'h00, wc 0.
  - FE: dt 6'h01, wc 0.
  - Line: dt 6'h2B, wc WC.
- State machine:
  - IDLE --fv_start--> FRAME (FS emitted).
  - FRAME --lv_start--> LINE (LP emitted; byte counter cleared).
  - LINE --lv_end--> FRAME (byte counter compared with WC; mismatch sets wc_err_o).
  - FRAME or LINE --fv_end--> IDLE (FE emitted). fv_end while in LINE also sets seq_err_o.
  - fv_start while in FRAME or LINE: set seq_err_o, emit FS, go to FRAME. The frame restarts.
  - lv_start in IDLE: ignored, set seq_err_o.
  - lv_start in LINE: set seq_err_o, restart the line (LP emitted, counter cleared).
  - fv_end in IDLE: ignored, set seq_err_o.
- Byte counter: 16-bit, increments on byte_en_i in LINE, saturates at 16'hFFFF. Bytes seen outside LINE are not counted.
- byte_data_o/byte_en_o equal the inputs delayed exactly DATA_DLY cycles, independent of state.
- frame_active_o is high in FRAME and LINE.
- seq_err_o and wc_err_o clear only on reset.
- Reset asserted mid-line: the pipeline flushes to 0 immediately; no FE is emitted.

Optional Feature:
- Macro: CSI_FRAME_NUM_EN.
- Defined: a 16-bit frame counter increments at each FS, starting at 1 and wrapping from FRAME_NUM_MAX back to 1 (never 0).
  - FS and the matching FE carry the current frame number in wc_o.
  - A restarted frame (fv_start while in a frame) still increments the counter.
- Undefined: the FS/FE wc is 0 and no counter logic is present.

Decomposition:
- Package csi_pkt_pkg holds:
  - typedef enum state_t {IDLE, FRAME, LINE};
  - constants DT_FS=6'h00, DT_FE=6'h01, DT_RAW10=6'h2B;
  - function calc_wc(h_pixels, bpp).
- Sub-module csi_delay_line (parameter DEPTH, WIDTH): reset-cleared shift register, instantiated with WIDTH 9 (byte_en + byte_data) and DEPTH DATA_DLY.

Test Plan:
- Reset then one frame of 8 lines, 320 bytes each:
  - Required: FS pulse with dt 00/wc 0, 8 LP pulses with dt 2B/wc 320, FE with dt 01.
  - Each pulse 1 cycle after its input; no error flags.
- Byte 0xA5 with byte_en_i at cycle N -> byte_data_o=0xA5, byte_en_o=1 at cycle N+3. d_hs_rdy_i at cycle N -> txfr_en_o at cycle N+1.
- A line of 319 bytes -> wc_err_o rises after that line's lv_end and stays 1 through the following frames.
- Sequence errors, each setting seq_err_o:
  - lv_start in IDLE -> no lp_en_o.
  - fv_start mid-line -> FS emitted, state FRAME.
- fv_end and lv_end in the same cycle with a 320-byte line -> FE emitted, no wc_err_o; state IDLE next cycle.
- With CSI_FRAME_NUM_EN and FRAME_NUM_MAX=3:
  - 4 frames -> FS wc sequence 1, 2, 3, 1.
  - Each FE wc equals its FS wc.
- Without CSI_FRAME_NUM_EN: FS/FE wc is always 0.

Source files
------------

// File: rtl/csi_pkt_pkg.sv
// csi_pkt_pkg: state encoding, CSI-2 data types and word-count helper shared by csi_pkt_sequencer.
package csi_pkt_pkg;
    typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;
    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    function automatic logic [15:0] calc_wc(input int h_pixels, input int bpp);
        return 16'(h_pixels * bpp / 8);
    endfunction
endpackage

// File: rtl/csi_delay_line.sv
// csi_delay_line: reset-cleared fixed-depth shift register.
module csi_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 9
) (
    input  logic             hf_clk90,
    input  logic             reset_n_byte,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/csi_pkt_sequencer.sv
// csi_pkt_sequencer: frame/line pulses to csi_tx short/long packet requests, delayed byte stream, debug error flags.
// Define CSI_FRAME_NUM_EN to carry a wrapping frame number (1..FRAME_NUM_MAX) in the FS/FE word count.
module csi_pkt_sequencer
    import csi_pkt_pkg::*;
#(
    parameter int          H_PIXELS      = 256,
    parameter int          BPP           = 10,
    parameter int          DATA_DLY      = 3,
    parameter logic [15:0] FRAME_NUM_MAX = 16'd65535
) (
    input  logic        hf_clk90,
    input  logic        reset_n_byte,
    input  logic        fv_start_i,
    input  logic        fv_end_i,
    input  logic        lv_start_i,
    input  logic        lv_end_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    input  logic        d_hs_rdy_i,
    output logic        sp_en_o,
    output logic        lp_en_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        byte_en_o,
    output logic [7:0]  byte_data_o,
    output logic        txfr_en_o,
    output logic        frame_active_o,
    output logic        seq_err_o,
    output logic        wc_err_o
);
    localparam logic [15:0] WC = calc_wc(H_PIXELS, BPP);
    if (H_PIXELS * BPP % 8 != 0 || DATA_DLY < 1 || DATA_DLY > 8 || FRAME_NUM_MAX == 16'd0) begin : g_bad_params
        $error("csi_pkt_sequencer: invalid parameters");
    end
    state_t      state;
    logic [15:0] byte_cnt;
    logic [15:0] fs_wc;
    logic [15:0] fe_wc;
    logic        line_end;
`ifdef CSI_FRAME_NUM_EN
    logic [15:0] frame_num;
    assign fs_wc = (frame_num == FRAME_NUM_MAX) ? 16'd1 : frame_num + 16'd1;
    assign fe_wc = frame_num;
`else
    assign fs_wc = '0;
    assign fe_wc = '0;
`endif
    assign line_end       = state == LINE && lv_end_i;
    assign frame_active_o = state != IDLE;
    csi_delay_line #(.DEPTH(DATA_DLY), .WIDTH(9)) u_dly (
        .hf_clk90     (hf_clk90),
        .reset_n_byte (reset_n_byte),
        .d            ({byte_en_i, byte_data_i}),
        .q            ({byte_en_o, byte_data_o})
    );
    // A coinciding lv_end closes the line before the frame/line event is judged.
    always_ff @(posedge hf_clk90 or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            sp_en_o   <= 1'b0;
            lp_en_o   <= 1'b0;
            dt_o      <= '0;
            wc_o      <= '0;
            txfr_en_o <= 1'b0;
            seq_err_o <= 1'b0;
            wc_err_o  <= 1'b0;
`ifdef CSI_FRAME_NUM_EN
            frame_num <= '0;
`endif
        end else begin
            sp_en_o   <= 1'b0;
            lp_en_o   <= 1'b0;
            txfr_en_o <= d_hs_rdy_i;
            if (state == LINE && byte_en_i && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
            if (line_end && byte_cnt != WC) wc_err_o <= 1'b1;
            if (fv_start_i) begin
                seq_err_o <= seq_err_o | (state != IDLE);
                state     <= FRAME;
                sp_en_o   <= 1'b1;
                dt_o      <= DT_FS;
                wc_o      <= fs_wc;
`ifdef CSI_FRAME_NUM_EN
                frame_num <= fs_wc;
`endif
            end else if (fv_end_i) begin
                seq_err_o <= seq_err_o | (state == IDLE) | (state == LINE && !lv_end_i);
                if (state != IDLE) begin
                    state   <= IDLE;
                    sp_en_o <= 1'b1;
                    dt_o    <= DT_FE;
                    wc_o    <= fe_wc;
                end
            end else if (lv_start_i) begin
                seq_err_o <= seq_err_o | (state == IDLE) | (state == LINE && !lv_end_i);
                if (state != IDLE) begin
                    state    <= LINE;
                    lp_en_o  <= 1'b1;
                    dt_o     <= DT_RAW10;
                    wc_o     <= WC;
                    byte_cnt <= '0;
                end
            end else if (line_end) begin
                state <= FRAME;
            end
        end
    end
endmodule

// File: tb/tb_csi_pkt_sequencer.sv
// tb_csi_pkt_sequencer: randomized scoreboard bench for csi_pkt_sequencer against a packet-level reference model.
module tb_csi_pkt_sequencer;
    localparam int DLY = 3;
    localparam int FNM = 3;
    localparam int WCV = 320;
`ifdef CSI_FRAME_NUM_EN
    localparam bit FN_EN = 1'b1;
`else
    localparam bit FN_EN = 1'b0;
`endif
    typedef struct { int cyc; bit sp; logic [5:0] dt; logic [15:0] wc; } pkt_t;
    typedef struct { int cyc; logic [7:0] d; } byte_t;
    typedef struct { int cyc; bit act; bit seq; bit wce; bit txfr; logic [5:0] dt; logic [15:0] wc; } flag_t;

    logic hf_clk90 = 1'b0, reset_n_byte = 1'b0;
    logic fv_start_i = 0, fv_end_i = 0, lv_start_i = 0, lv_end_i = 0, byte_en_i = 0, d_hs_rdy_i = 0;
    logic [7:0] byte_data_i = '0;
    logic sp_en_o, lp_en_o, byte_en_o, txfr_en_o, frame_active_o, seq_err_o, wc_err_o;
    logic [5:0] dt_o;
    logic [15:0] wc_o;
    logic [7:0] byte_data_o;

    csi_pkt_sequencer #(.H_PIXELS(256), .BPP(10), .DATA_DLY(DLY), .FRAME_NUM_MAX(16'(FNM))) dut (
        .hf_clk90(hf_clk90), .reset_n_byte(reset_n_byte),
        .fv_start_i(fv_start_i), .fv_end_i(fv_end_i), .lv_start_i(lv_start_i), .lv_end_i(lv_end_i),
        .byte_en_i(byte_en_i), .byte_data_i(byte_data_i), .d_hs_rdy_i(d_hs_rdy_i),
        .sp_en_o(sp_en_o), .lp_en_o(lp_en_o), .dt_o(dt_o), .wc_o(wc_o),
        .byte_en_o(byte_en_o), .byte_data_o(byte_data_o), .txfr_en_o(txfr_en_o),
        .frame_active_o(frame_active_o), .seq_err_o(seq_err_o), .wc_err_o(wc_err_o)
    );

    always #5 hf_clk90 = ~hf_clk90;

    int cyc = 0, n_cmp = 0, n_err = 0;
    always @(posedge hf_clk90) cyc <= cyc + 1;

    pkt_t  pq[$];
    byte_t bq[$];
    flag_t fq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: 0 = outside frame, 1 = in frame, 2 = in line.
    int m_state = 0, m_cnt = 0, m_nfs = 0;
    bit m_seq = 0, m_wce = 0;
    logic [5:0] m_dt = '0;
    logic [15:0] m_wc = '0;

    function automatic logic [15:0] fnum(input int n);
        return FN_EN ? 16'((n - 1) % FNM + 1) : 16'd0;
    endfunction

    task automatic emit(input bit sp, input logic [5:0] dt, input logic [15:0] wc);
        m_dt = dt;
        m_wc = wc;
        pq.push_back('{cyc + 1, sp, dt, wc});
    endtask

    task automatic model(input bit fs, input bit fe, input bit ls, input bit le, input bit ben);
        bit closed = (m_state == 2) && le;
        if (closed && m_cnt != WCV) m_wce = 1;
        if (m_state == 2 && ben && m_cnt < 65535) m_cnt++;
        if (closed) m_state = 1;
        if (fs) begin
            if (m_state != 0) m_seq = 1;
            m_nfs++;
            m_state = 1;
            emit(1, 6'h00, fnum(m_nfs));
        end else if (fe) begin
            if (m_state != 1) m_seq = 1;
            if (m_state != 0) begin
                m_state = 0;
                emit(1, 6'h01, fnum(m_nfs));
            end
        end else if (ls) begin
            if (m_state != 1) m_seq = 1;
            if (m_state != 0) begin
                m_state = 2;
                m_cnt = 0;
                emit(0, 6'h2B, 16'(WCV));
            end
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_nfs = 0; m_seq = 0; m_wce = 0; m_dt = '0; m_wc = '0;
        pq.delete(); bq.delete(); fq.delete();
    endtask

    task automatic step(input bit fs, input bit fe, input bit ls, input bit le, input bit ben, input logic [7:0] d);
        bit rdy = 1'($urandom);
        @(negedge hf_clk90);
        fv_start_i = fs; fv_end_i = fe; lv_start_i = ls; lv_end_i = le;
        byte_en_i = ben; byte_data_i = d; d_hs_rdy_i = rdy;
        model(fs, fe, ls, le, ben);
        if (ben) bq.push_back('{cyc + DLY, d});
        fq.push_back('{cyc + 1, m_state != 0, m_seq, m_wce, rdy, m_dt, m_wc});
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic line(input int nb, input bit with_fe = 0);
        step(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 7) == 0) step(0, 0, 0, 0, 0, 8'($urandom));
            step(0, 0, 0, 0, 1, 8'($urandom));
        end
        step(0, with_fe, 0, 1, 0, 8'h00);
    endtask

    task automatic frame(input int nl, input int nb);
        step(1, 0, 0, 0, 0, 8'h00);
        idle(1);
        for (int i = 0; i < nl; i++) begin
            line(nb);
            idle(1);
        end
        step(0, 1, 0, 0, 0, 8'h00);
        idle(1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sp_en"}, sp_en_o, 0);
        chk({tag, "_lp_en"}, lp_en_o, 0);
        chk({tag, "_dt"}, dt_o, 0);
        chk({tag, "_wc"}, wc_o, 0);
        chk({tag, "_byte_en"}, byte_en_o, 0);
        chk({tag, "_byte_data"}, byte_data_o, 0);
        chk({tag, "_txfr_en"}, txfr_en_o, 0);
        chk({tag, "_frame_active"}, frame_active_o, 0);
        chk({tag, "_seq_err"}, seq_err_o, 0);
        chk({tag, "_wc_err"}, wc_err_o, 0);
    endtask

    pkt_t  mp;
    byte_t mb;
    flag_t mf;
    always @(negedge hf_clk90) if (reset_n_byte) begin
        if (sp_en_o || lp_en_o) begin
            if (pq.size() == 0) chk("pkt_unexpected", {sp_en_o, lp_en_o}, 0);
            else begin
                mp = pq.pop_front();
                chk("pkt_kind", {sp_en_o, lp_en_o}, {mp.sp, !mp.sp});
                chk("pkt_cycle", cyc, mp.cyc);
                chk("pkt_dt", dt_o, mp.dt);
                chk("pkt_wc", wc_o, mp.wc);
            end
        end else if (pq.size() != 0 && pq[0].cyc <= cyc) begin
            mp = pq.pop_front();
            chk("pkt_missing", {sp_en_o, lp_en_o}, {mp.sp, !mp.sp});
        end
        if (byte_en_o) begin
            if (bq.size() == 0) chk("byte_unexpected", byte_en_o, 0);
            else begin
                mb = bq.pop_front();
                chk("byte_cycle", cyc, mb.cyc);
                chk("byte_data", byte_data_o, mb.d);
            end
        end else if (bq.size() != 0 && bq[0].cyc <= cyc) begin
            mb = bq.pop_front();
            chk("byte_missing", byte_en_o, 1);
        end
        if (fq.size() != 0 && fq[0].cyc == cyc) begin
            mf = fq.pop_front();
            chk("frame_active", frame_active_o, mf.act);
            chk("seq_err", seq_err_o, mf.seq);
            chk("wc_err", wc_err_o, mf.wce);
            chk("txfr_en", txfr_en_o, mf.txfr);
            chk("dt_hold", dt_o, mf.dt);
            chk("wc_hold", wc_o, mf.wc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge hf_clk90);
        check_zero("rst");
        #2 reset_n_byte = 1'b1;
        idle(2);
        step(0, 0, 0, 0, 1, 8'hA5);
        idle(DLY + 1);
        frame(8, WCV);
        step(1, 0, 0, 0, 0, 8'h00);
        line(WCV);
        line(WCV - 1);
        line(WCV);
        step(0, 1, 0, 0, 0, 8'h00);
        idle(2);
        frame(2, WCV);
        step(0, 0, 1, 0, 0, 8'h00);
        idle(2);
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        repeat (40) step(0, 0, 0, 0, 1, 8'($urandom));
        step(1, 0, 0, 0, 0, 8'h00);
        line(WCV);
        step(0, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        line(WCV, 1'b1);
        idle(2);
        step(0, 1, 0, 0, 0, 8'h00);
        idle(2);
        repeat (400) step($urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                          $urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        repeat (20) step(0, 0, 0, 0, 1, 8'($urandom));
        #2 reset_n_byte = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        fv_start_i = 0; fv_end_i = 0; lv_start_i = 0; lv_end_i = 0; byte_en_i = 0; d_hs_rdy_i = 0;
        repeat (2) @(negedge hf_clk90);
        #2 reset_n_byte = 1'b1;
        frame(2, WCV);
        frame(1, WCV);
        idle(DLY + 3);
        @(negedge hf_clk90);
        chk("pkt_drained", pq.size(), 0);
        chk("byte_drained", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
